// File: rtl/gaussian_pkg.sv
// Shared constants for the Gaussian coefficient sequencer: kernel weights,
// divisors, kernel sizes, FSM states and the fixed-point rounding function.
package gaussian_pkg;

  localparam int K3   = 3;
  localparam int K5   = 5;
  localparam int DIV3 = 16;
  localparam int DIV5 = 159;

  localparam int K3_W [9] = '{1, 2, 1,
                              2, 4, 2,
                              1, 2, 1};

  localparam int K5_W [25] = '{2,  4,  5,  4, 2,
                               4,  9, 12,  9, 4,
                               5, 12, 15, 12, 5,
                               4,  9, 12,  9, 4,
                               2,  4,  5,  4, 2};

  typedef enum logic {IDLE, STREAM} state_e;

  // round(n/d * 2^frac_w), half up: floor((2*n*2^f + d) / (2*d))
  function automatic longint coef_q(input int n, input int d, input int frac_w);
    longint num;
    num = longint'(n) << frac_w;
    return (2 * num + longint'(d)) / (2 * longint'(d));
  endfunction

endpackage

// File: rtl/gaussian_coeff_table.sv
// Coefficient lookup for the 3x3 and 5x5 kernels. Constant ROM by default;
// a reset-loaded writable register file when GAUSS_COEF_WR_EN is defined.
module gaussian_coeff_table
  import gaussian_pkg::*;
#(
  parameter int COEF_W = 16,
  parameter int FRAC_W = 12
) (
`ifdef GAUSS_COEF_WR_EN
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic              wr_ksel_i,
  input  logic [4:0]        wr_addr_i,
  input  logic [COEF_W-1:0] wr_data_i,
`endif
  input  logic              ksel_i,
  input  logic [4:0]        idx_i,
  output logic [COEF_W-1:0] coef_o
);

  logic [COEF_W-1:0] rom3 [9];
  logic [COEF_W-1:0] rom5 [25];

  for (genvar i = 0; i < 9; i++) begin : g_rom3
    localparam longint V = coef_q(K3_W[i], DIV3, FRAC_W);
    if (V >= (longint'(1) << COEF_W)) begin : g_ovf
      $error("gaussian_coeff_table: 3x3 coefficient does not fit COEF_W");
    end
    assign rom3[i] = V[COEF_W-1:0];
  end

  for (genvar i = 0; i < 25; i++) begin : g_rom5
    localparam longint V = coef_q(K5_W[i], DIV5, FRAC_W);
    if (V >= (longint'(1) << COEF_W)) begin : g_ovf
      $error("gaussian_coeff_table: 5x5 coefficient does not fit COEF_W");
    end
    assign rom5[i] = V[COEF_W-1:0];
  end

`ifdef GAUSS_COEF_WR_EN
  logic [COEF_W-1:0] t3_q [9];
  logic [COEF_W-1:0] t5_q [25];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 9; i++)  t3_q[i] <= rom3[i];
      for (int i = 0; i < 25; i++) t5_q[i] <= rom5[i];
    end else if (wr_en_i) begin
      if (!wr_ksel_i && wr_addr_i < 5'd9)      t3_q[wr_addr_i[3:0]] <= wr_data_i;
      else if (wr_ksel_i && wr_addr_i < 5'd25) t5_q[wr_addr_i]      <= wr_data_i;
    end
  end

  // Forward a same-cycle write so the next coefficient loaded already sees it.
  always_comb begin
    coef_o = '0;
    if (wr_en_i && wr_ksel_i == ksel_i && wr_addr_i == idx_i &&
        wr_addr_i < (wr_ksel_i ? 5'd25 : 5'd9))
      coef_o = wr_data_i;
    else if (ksel_i && idx_i < 5'd25)
      coef_o = t5_q[idx_i];
    else if (!ksel_i && idx_i < 5'd9)
      coef_o = t3_q[idx_i[3:0]];
  end
`else
  always_comb begin
    coef_o = '0;
    if (ksel_i && idx_i < 5'd25)
      coef_o = rom5[idx_i];
    else if (!ksel_i && idx_i < 5'd9)
      coef_o = rom3[idx_i[3:0]];
  end
`endif

endmodule

// File: rtl/gaussian_coeff_seq.sv
// Streams a 3x3 or 5x5 Gaussian kernel in raster order over valid/ready.
// Optional table write port enabled with GAUSS_COEF_WR_EN.
module gaussian_coeff_seq
  import gaussian_pkg::*;
#(
  parameter int COEF_W = 16,
  parameter int FRAC_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              ksel_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              coef_valid_o,
  input  logic              coef_ready_i,
  output logic [COEF_W-1:0] coef_data_o,
  output logic [2:0]        coef_row_o,
  output logic [2:0]        coef_col_o,
  output logic              coef_last_o,
`ifdef GAUSS_COEF_WR_EN
  input  logic              wr_en_i,
  input  logic              wr_ksel_i,
  input  logic [4:0]        wr_addr_i,
  input  logic [COEF_W-1:0] wr_data_i,
`endif
  output logic              done_o
);

  if (FRAC_W < 8 || FRAC_W > COEF_W - 1) begin : g_bad_frac
    $error("gaussian_coeff_seq: FRAC_W must lie in 8..COEF_W-1");
  end

  state_e            state_q, state_d;
  logic              ksel_q, ksel_d;
  logic [4:0]        idx_q, idx_d;
  logic [2:0]        row_q, row_d;
  logic [2:0]        col_q, col_d;
  logic [COEF_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              done_q, done_d;

  logic              hs, accept, rd_ksel;
  logic [4:0]        rd_idx, last_idx;
  logic [2:0]        nm1;
  logic [COEF_W-1:0] tbl_coef;

  assign busy_o       = (state_q == STREAM);
  assign coef_valid_o = (state_q == STREAM);
  assign coef_data_o  = data_q;
  assign coef_row_o   = row_q;
  assign coef_col_o   = col_q;
  assign coef_last_o  = last_q;
  assign done_o       = done_q;

  assign hs       = coef_valid_o & coef_ready_i;
  assign last_idx = ksel_q ? 5'(K5 * K5 - 1) : 5'(K3 * K3 - 1);
  assign nm1      = ksel_q ? 3'(K5 - 1) : 3'(K3 - 1);

  // A start on the final handshake chains straight into the next stream.
  assign accept  = (state_q == IDLE && start_i) ||
                   (state_q == STREAM && !abort_i && hs && last_q && start_i);
  assign rd_ksel = accept ? ksel_i : ksel_q;
  assign rd_idx  = accept ? 5'd0 : idx_q + 5'd1;

  gaussian_coeff_table #(
    .COEF_W (COEF_W),
    .FRAC_W (FRAC_W)
  ) u_table (
`ifdef GAUSS_COEF_WR_EN
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (wr_en_i),
    .wr_ksel_i (wr_ksel_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
`endif
    .ksel_i    (rd_ksel),
    .idx_i     (rd_idx),
    .coef_o    (tbl_coef)
  );

  always_comb begin
    state_d = state_q;
    ksel_d  = ksel_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = STREAM;
          ksel_d  = ksel_i;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          data_d  = tbl_coef;
          last_d  = 1'b0;
        end
      end
      STREAM: begin
        if (abort_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (hs && last_q) begin
          done_d = 1'b1;
          if (accept) begin
            ksel_d = ksel_i;
            idx_d  = '0;
            row_d  = '0;
            col_d  = '0;
            data_d = tbl_coef;
          end else begin
            state_d = IDLE;
          end
          last_d = 1'b0;
        end else if (hs) begin
          idx_d  = idx_q + 5'd1;
          data_d = tbl_coef;
          last_d = ((idx_q + 5'd1) == last_idx);
          if (col_q == nm1) begin
            col_d = '0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ksel_q  <= 1'b0;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ksel_q  <= ksel_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_gaussian_coeff_seq.sv
// Randomized self-checking bench for gaussian_coeff_seq against a real-valued
// kernel model; write-port scenario included when GAUSS_COEF_WR_EN is defined.
module tb_gaussian_coeff_seq;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        ksel_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        coef_ready_i = 1'b0;
  logic        busy_o, coef_valid_o, coef_last_o, done_o;
  logic [15:0] coef_data_o;
  logic [2:0]  coef_row_o, coef_col_o;
`ifdef GAUSS_COEF_WR_EN
  logic        wr_en_i = 1'b0;
  logic        wr_ksel_i = 1'b0;
  logic [4:0]  wr_addr_i = '0;
  logic [15:0] wr_data_i = '0;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] seen_d [25];

  int W3 [9]  = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
  int W5 [25] = '{2, 4, 5, 4, 2, 4, 9, 12, 9, 4, 5, 12, 15, 12, 5,
                  4, 9, 12, 9, 4, 2, 4, 5, 4, 2};
  logic [15:0] ovr_val = '0;
  int          ovr_idx = -1;

  gaussian_coeff_seq #(.COEF_W(16), .FRAC_W(12)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .ksel_i       (ksel_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .coef_valid_o (coef_valid_o),
    .coef_ready_i (coef_ready_i),
    .coef_data_o  (coef_data_o),
    .coef_row_o   (coef_row_o),
    .coef_col_o   (coef_col_o),
    .coef_last_o  (coef_last_o),
`ifdef GAUSS_COEF_WR_EN
    .wr_en_i      (wr_en_i),
    .wr_ksel_i    (wr_ksel_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
`endif
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: round half up of weight/divisor scaled by 2^12.
  function automatic logic [15:0] exp_coef(input bit ks, input int i);
    real v;
    if (ks && i == ovr_idx) return ovr_val;
    v = ks ? (W5[i] * 4096.0 / 159.0) : (W3[i] * 4096.0 / 16.0);
    return 16'($rtoi($floor(v + 0.5)));
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start(input bit ks);
    start_i = 1'b1;
    ksel_i  = ks;
    tick();
    start_i = 1'b0;
  endtask

  // Drives one stream from its first presented coefficient; rmode 0 = ready
  // high, 1 = toggling 1010, 2 = random. Returns after last handshake or abort.
  task automatic run_stream(input bit ks, input int rmode, input int abort_at,
                            input int bs_at, input bit chain, input bit chain_ks);
    int n = ks ? 5 : 3;
    int total = n * n;
    int idx = 0;
    int cyc = 0;
    bit rdy, ab, tog;
    logic [15:0] e;
    ab  = 1'b0;
    tog = 1'b1;
    while (idx < total && cyc < 300) begin
      e = exp_coef(ks, idx);
      checks++;
      if ({coef_valid_o, busy_o, coef_data_o, coef_row_o, coef_col_o, coef_last_o} !==
          {1'b1, 1'b1, e, 3'(idx / n), 3'(idx % n), (idx == total - 1)}) begin
        errors++;
        $display("FAIL stream ks=%0d idx=%0d got v=%0b b=%0b d=%h r=%0d c=%0d l=%0b want d=%h r=%0d c=%0d",
                 ks, idx, coef_valid_o, busy_o, coef_data_o, coef_row_o, coef_col_o,
                 coef_last_o, e, idx / n, idx % n);
      end
      if (cyc > 0) begin
        checks++;
        if (done_o !== 1'b0) begin
          errors++;
          $display("FAIL done_mid ks=%0d idx=%0d got %0b want 0", ks, idx, done_o);
        end
      end
      seen_d[idx] = coef_data_o;
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      coef_ready_i = rdy;
      ab = (idx == abort_at);
      abort_i = ab;
      start_i = (idx == bs_at) || (chain && idx == total - 1 && rdy);
      ksel_i  = (idx == bs_at) ? !ks : chain_ks;
      tick();
      start_i = 1'b0;
      abort_i = 1'b0;
      coef_ready_i = 1'b0;
      if (ab) break;
      if (rdy) idx++;
      cyc++;
    end
    if (!ab && idx < total) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout ks=%0d got idx %0d want %0d", ks, idx, total);
    end
  endtask

  task automatic expect_end(input string nm, input logic [3:0] want);
    checks++;
    if ({done_o, busy_o, coef_valid_o, coef_last_o} !== want) begin
      errors++;
      $display("FAIL %s done/busy/valid/last got %b want %b", nm, {done_o, busy_o, coef_valid_o, coef_last_o}, want);
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy_o, coef_valid_o, coef_data_o, coef_row_o, coef_col_o, coef_last_o, done_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got d=%h b=%0b v=%0b want all 0", coef_data_o, busy_o, coef_valid_o);
    end
    rst_n_i = 1'b1;
    tick();
    expect_end("idle_after_reset", 4'b0000);
  endtask

  task automatic test_5x5();
    pulse_start(1'b1);
    run_stream(1'b1, 0, -1, -1, 1'b0, 1'b0);
    expect_end("done_5x5", 4'b1000);
    checks++;
    if ({seen_d[0], seen_d[1], seen_d[2], seen_d[6], seen_d[7], seen_d[12]} !==
        {16'h0034, 16'h0067, 16'h0081, 16'h00E8, 16'h0135, 16'h0182}) begin
      errors++;
      $display("FAIL k5_constants got %h %h %h %h %h %h", seen_d[0], seen_d[1], seen_d[2],
               seen_d[6], seen_d[7], seen_d[12]);
    end
    tick();
    expect_end("done_pulse_5x5", 4'b0000);
  endtask

  task automatic test_3x3_toggle();
    pulse_start(1'b0);
    run_stream(1'b0, 1, -1, -1, 1'b0, 1'b0);
    expect_end("done_3x3", 4'b1000);
    checks++;
    if ({seen_d[0], seen_d[1], seen_d[2], seen_d[3], seen_d[4]} !==
        {16'h0100, 16'h0200, 16'h0100, 16'h0200, 16'h0400}) begin
      errors++;
      $display("FAIL k3_constants got %h %h %h %h %h", seen_d[0], seen_d[1], seen_d[2], seen_d[3], seen_d[4]);
    end
    tick();
  endtask

  task automatic test_abort();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    expect_end("abort_idle", 4'b0000);
    pulse_start(1'b1);
    run_stream(1'b1, 0, 6, -1, 1'b0, 1'b0);
    expect_end("abort_next", 4'b0000);
    tick();
    expect_end("abort_no_done", 4'b0000);
    pulse_start(1'b1);
    run_stream(1'b1, 0, -1, -1, 1'b0, 1'b0);
    expect_end("restart_done", 4'b1000);
    tick();
  endtask

  task automatic test_back_to_back();
    pulse_start(1'b1);
    run_stream(1'b1, 0, -1, 4, 1'b1, 1'b0);
    expect_end("chain_overlap", 4'b1110);
    run_stream(1'b0, 0, -1, -1, 1'b0, 1'b0);
    expect_end("chain_done", 4'b1000);
    tick();
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      bit ks = 1'($urandom_range(0, 1));
      pulse_start(ks);
      run_stream(ks, 2, -1, 2, 1'b0, 1'b0);
      expect_end("rand_done", 4'b1000);
      repeat ($urandom_range(1, 3)) tick();
      expect_end("rand_idle", 4'b0000);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start(1'b1);
    coef_ready_i = 1'b1;
    repeat (4) tick();
    rst_n_i = 1'b0;
    tick();
    coef_ready_i = 1'b0;
    checks++;
    if ({busy_o, coef_valid_o, coef_data_o, coef_row_o, coef_col_o, coef_last_o, done_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid got d=%h r=%0d c=%0d v=%0b want all 0", coef_data_o, coef_row_o, coef_col_o, coef_valid_o);
    end
    rst_n_i = 1'b1;
    tick();
    pulse_start(1'b0);
    run_stream(1'b0, 0, -1, -1, 1'b0, 1'b0);
    expect_end("post_reset_done", 4'b1000);
    tick();
  endtask

`ifdef GAUSS_COEF_WR_EN
  task automatic test_write();
    wr_en_i = 1'b1; wr_ksel_i = 1'b1; wr_addr_i = 5'd12; wr_data_i = 16'h0200;
    tick();
    wr_addr_i = 5'd30; wr_data_i = 16'hFFFF;
    tick();
    wr_en_i = 1'b0;
    ovr_idx = 12; ovr_val = 16'h0200;
    pulse_start(1'b1);
    run_stream(1'b1, 0, -1, -1, 1'b0, 1'b0);
    tick();
    ovr_idx = -1;
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    tick();
    pulse_start(1'b1);
    run_stream(1'b1, 0, -1, -1, 1'b0, 1'b0);
    checks++;
    if (seen_d[12] !== 16'h0182) begin
      errors++;
      $display("FAIL write_reset got %h want 0182", seen_d[12]);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_5x5();
    test_3x3_toggle();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef GAUSS_COEF_WR_EN
    test_write();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
